// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the core memory-port arbiter: FSM states and owner ids.
package mem_bus_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;
endpackage

// File: rtl/mem_bus_arbiter_grant_sel.sv
// Grant selection between IFU and LSU: LSU first unless the IFU has waited
// through a full run of back-to-back LSU grants.
module arb_grant_sel (
  input  logic ifu_valid,
  input  logic lsu_valid,
  input  logic run_at_max,
  output logic grant_ifu,
  output logic grant_lsu
);
  assign grant_lsu = lsu_valid & ~(ifu_valid & run_at_max);
  assign grant_ifu = ifu_valid & ~grant_lsu;
endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-outstanding arbiter sharing one memory port between IFU and LSU:
// grant, issue a registered request, route the response to its owner, release.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MASK_W      = 8,
  parameter int LSU_MAX_RUN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_req_addr,
  output logic              ifu_resp_valid,
  input  logic              ifu_resp_ready,
  output logic [DATA_W-1:0] ifu_resp_rdata,
  output logic              ifu_resp_err,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic              lsu_req_wen,
  input  logic [DATA_W-1:0] lsu_req_wdata,
  input  logic [MASK_W-1:0] lsu_req_wmask,
  output logic              lsu_resp_valid,
  input  logic              lsu_resp_ready,
  output logic [DATA_W-1:0] lsu_resp_rdata,
  output logic              lsu_resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [MASK_W-1:0] mem_req_wmask,
  input  logic              mem_resp_valid,
  output logic              mem_resp_ready,
  input  logic [DATA_W-1:0] mem_resp_rdata,
  input  logic              mem_resp_err
);
  localparam int RUN_W = $clog2(LSU_MAX_RUN + 1);

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic [RUN_W-1:0]    run_q, run_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;

  logic grant_ifu, grant_lsu, run_at_max;
  logic in_idle, in_issue, in_wait, to_ifu, to_lsu;

  assign run_at_max = (run_q == RUN_W'(LSU_MAX_RUN));

  arb_grant_sel u_grant_sel (
    .ifu_valid  (ifu_req_valid),
    .lsu_valid  (lsu_req_valid),
    .run_at_max (run_at_max),
    .grant_ifu  (grant_ifu),
    .grant_lsu  (grant_lsu)
  );

  // Reset masks every handshake so nothing is accepted or forwarded while it is held.
  assign in_idle  = (state_q == ST_IDLE)  & ~rst;
  assign in_issue = (state_q == ST_ISSUE) & ~rst;
  assign in_wait  = (state_q == ST_WAIT)  & ~rst;
  assign to_ifu   = in_wait & (owner_q == OWN_IFU);
  assign to_lsu   = in_wait & (owner_q == OWN_LSU);

  assign ifu_req_ready  = in_idle & grant_ifu;
  assign lsu_req_ready  = in_idle & grant_lsu;

  assign mem_req_valid  = in_issue;
  assign mem_req_addr   = addr_q;
  assign mem_req_wen    = wen_q;
  assign mem_req_wdata  = wdata_q;
  assign mem_req_wmask  = wmask_q;

  assign mem_resp_ready = (to_ifu & ifu_resp_ready) | (to_lsu & lsu_resp_ready);
  assign ifu_resp_valid = to_ifu & mem_resp_valid;
  assign ifu_resp_rdata = to_ifu ? mem_resp_rdata : '0;
  assign ifu_resp_err   = to_ifu & mem_resp_err;
  assign lsu_resp_valid = to_lsu & mem_resp_valid;
  assign lsu_resp_rdata = to_lsu ? mem_resp_rdata : '0;
  assign lsu_resp_err   = to_lsu & mem_resp_err;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    run_d   = run_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_lsu) begin
          state_d = ST_ISSUE;
          owner_d = OWN_LSU;
          addr_d  = lsu_req_addr;
          wen_d   = lsu_req_wen;
          wdata_d = lsu_req_wdata;
          wmask_d = lsu_req_wmask;
          // Only runs that actually keep the IFU waiting count toward starvation.
          if (!ifu_req_valid)  run_d = '0;
          else if (!run_at_max) run_d = run_q + 1'b1;
        end else if (grant_ifu) begin
          state_d = ST_ISSUE;
          owner_d = OWN_IFU;
          addr_d  = ifu_req_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wmask_d = '0;
          run_d   = '0;
        end
      end
      ST_ISSUE: if (mem_req_ready) state_d = ST_WAIT;
      ST_WAIT:  if (mem_resp_valid && mem_resp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IFU;
      run_q   <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      run_q   <= run_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: reads, writes, priority, starvation guard,
// response backpressure and reset abandoning an in-flight transaction.
module tb_mem_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_resp_valid, ifu_resp_ready, ifu_resp_err;
  logic [31:0] ifu_resp_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen;
  logic [31:0] lsu_req_addr, lsu_req_wdata;
  logic [7:0]  lsu_req_wmask;
  logic        lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
  logic [31:0] lsu_resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid, mem_resp_ready, mem_resp_err;
  logic [31:0] mem_resp_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MASK_W(8), .LSU_MAX_RUN(4)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
    .ifu_resp_rdata(ifu_resp_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
    .lsu_resp_rdata(lsu_resp_rdata), .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_resp_rdata(mem_resp_rdata), .mem_resp_err(mem_resp_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed 1 ns after the edge, outputs checked 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    ifu_req_valid = 0; ifu_req_addr = '0; ifu_resp_ready = 1;
    lsu_req_valid = 0; lsu_req_addr = '0; lsu_req_wen = 0; lsu_req_wdata = '0; lsu_req_wmask = '0;
    lsu_resp_ready = 1;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0; mem_resp_err = 0;
    tick(); tick();
    rst = 1'b0;
    settle();
    chk("rst_ifu_req_ready", ifu_req_ready, 0);
    chk("rst_lsu_req_ready", lsu_req_ready, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_resp_ready", mem_resp_ready, 0);
    chk("rst_mem_req_addr", mem_req_addr, 0);
    chk("rst_resp_valids", {ifu_resp_valid, lsu_resp_valid}, 0);

    // Single IFU read
    tick();
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000; mem_req_ready = 1;
    settle();
    chk("ifu_rd_grant", {ifu_req_ready, lsu_req_ready}, 2'b10);
    tick();
    ifu_req_valid = 0;
    settle();
    chk("ifu_rd_mem_valid", mem_req_valid, 1);
    chk("ifu_rd_mem_addr", mem_req_addr, 32'h8000_0000);
    chk("ifu_rd_mem_wen", {mem_req_wen, mem_req_wdata, mem_req_wmask}, 0);
    tick();
    mem_resp_valid = 1; mem_resp_rdata = 32'h0000_0413;
    settle();
    chk("ifu_rd_resp_valid", ifu_resp_valid, 1);
    chk("ifu_rd_resp_rdata", ifu_resp_rdata, 32'h0000_0413);
    chk("ifu_rd_lsu_quiet", {lsu_resp_valid, lsu_resp_rdata}, 0);
    chk("ifu_rd_mem_resp_ready", mem_resp_ready, 1);
    tick();
    mem_resp_valid = 0;
    settle();
    chk("ifu_rd_back_idle", {mem_req_valid, ifu_resp_valid}, 0);

    // LSU write with downstream stall
    lsu_req_valid = 1; lsu_req_addr = 32'h8000_1000; lsu_req_wen = 1;
    lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 8'h0F; mem_req_ready = 0;
    settle();
    chk("lsu_wr_grant", {ifu_req_ready, lsu_req_ready}, 2'b01);
    tick();
    lsu_req_valid = 0; lsu_req_addr = 32'h1234_5678; lsu_req_wdata = 32'h0; lsu_req_wmask = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("lsu_wr_stall_valid", mem_req_valid, 1);
      chk("lsu_wr_stall_fields", {mem_req_addr, mem_req_wdata},
          {32'h8000_1000, 32'hDEAD_BEEF});
      chk("lsu_wr_stall_wen_mask", {mem_req_wen, mem_req_wmask}, {1'b1, 8'h0F});
      tick();
    end
    mem_req_ready = 1;
    settle();
    chk("lsu_wr_issue_valid", mem_req_valid, 1);
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h5555_5555;
    settle();
    chk("lsu_wr_resp_valid", {ifu_resp_valid, lsu_resp_valid}, 2'b01);
    chk("lsu_wr_resp_err", lsu_resp_err, 0);
    tick();
    mem_resp_valid = 0;

    // Simultaneous requests: LSU first, IFU right after the LSU handshake
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0004;
    lsu_req_valid = 1; lsu_req_wen = 0; lsu_req_addr = 32'h8000_2000;
    mem_req_ready = 1;
    settle();
    chk("sim_first_grant", {ifu_req_ready, lsu_req_ready}, 2'b01);
    tick();
    lsu_req_valid = 0;
    settle();
    chk("sim_issue_no_grant", ifu_req_ready, 0);
    chk("sim_issue_addr", mem_req_addr, 32'h8000_2000);
    tick();
    mem_resp_valid = 1;
    settle();
    chk("sim_wait_no_grant", {ifu_req_ready, lsu_resp_valid}, 2'b01);
    tick();
    mem_resp_valid = 0;
    settle();
    chk("sim_second_grant", {ifu_req_ready, lsu_req_ready}, 2'b10);
    tick();
    ifu_req_valid = 0;
    settle();
    chk("sim_ifu_issue_addr", mem_req_addr, 32'h8000_0004);
    tick();
    mem_resp_valid = 1;
    tick();
    mem_resp_valid = 0;

    // Starvation guard: both requesting continuously, 3-cycle transactions
    ifu_req_valid = 1; lsu_req_valid = 1; mem_req_ready = 1; mem_resp_valid = 1;
    for (int k = 0; k < 10; k++) begin
      settle();
      chk($sformatf("starve_grant_%0d", k), {ifu_req_ready, lsu_req_ready},
          (k % 5 == 4) ? 2'b10 : 2'b01);
      tick(); tick(); tick();
    end
    ifu_req_valid = 0; lsu_req_valid = 0; mem_resp_valid = 0;
    settle();
    chk("starve_back_idle", {ifu_req_ready, lsu_req_ready, mem_req_valid}, 0);

    // Response backpressure and error propagation
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0100; ifu_resp_ready = 0;
    tick();
    ifu_req_valid = 0;
    tick();
    mem_resp_valid = 1; mem_resp_err = 1; mem_resp_rdata = 32'h0000_1234; lsu_req_valid = 1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("bp_mem_resp_ready", mem_resp_ready, 0);
      chk("bp_hold_wait", {ifu_resp_valid, mem_req_valid, lsu_req_ready}, 3'b100);
      tick();
    end
    ifu_resp_ready = 1; lsu_req_valid = 0;
    settle();
    chk("bp_handshake", {mem_resp_ready, ifu_resp_valid}, 2'b11);
    chk("bp_err", {ifu_resp_err, ifu_resp_rdata}, {1'b1, 32'h0000_1234});
    tick();
    mem_resp_valid = 0; mem_resp_err = 0;
    settle();
    chk("bp_released", {ifu_resp_valid, mem_resp_ready}, 0);

    // Reset while waiting on a response
    lsu_req_valid = 1; lsu_req_addr = 32'h8000_3000;
    tick();
    lsu_req_valid = 0;
    tick();
    mem_resp_valid = 1; mem_resp_rdata = 32'hAAAA_AAAA; lsu_resp_ready = 1; rst = 1;
    settle();
    chk("rstw_no_forward", {lsu_resp_valid, mem_resp_ready}, 0);
    tick();
    rst = 0;
    settle();
    chk("rstw_outputs", {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_resp_ready,
                         ifu_resp_valid, lsu_resp_valid}, 0);
    chk("rstw_latched_cleared", {mem_req_addr, mem_req_wen}, 0);
    chk("rstw_rdata_zero", lsu_resp_rdata, 0);
    tick();
    settle();
    chk("rstw_still_dropped", {lsu_resp_valid, mem_resp_ready, mem_req_valid}, 0);
    mem_resp_valid = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
